// File: rtl/vertical_sync.sv
// ---------------------------------------------------------------------------
// vertical_sync
// Vertical timing stage of the VGA encoder. Counts lines using the one-cycle
// end-of-line pulse from the horizontal stage, and produces vertical sync, the
// visible-window flag, the current line number and frame boundary pulses.
//
// Ports:
//   pixel_clk    in   1       pixel clock, rising edge
//   reset        in   1       asynchronous active-high reset
//   line_end     in   1       one-cycle pulse on the last pixel of a line
//   v_sync       out  1       vertical sync, asserted level = SYNC_POL
//   v_active     out  1       high while the line is in the visible window
//   line_y       out  LINE_W  current line number, 0..V_TOTAL-1
//   frame_start  out  1       one-cycle pulse when line_y wraps to 0
//   frame_end    out  1       one-cycle pulse when line_y becomes V_ACTIVE
//   frame_count  out  8       frames completed, mod 256
//                             (present only with VSYNC_FRAME_COUNT_EN)
//
// Build option: define VSYNC_FRAME_COUNT_EN to add the frame_count port.
// ---------------------------------------------------------------------------
module vertical_sync #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned LINE_W   = 10
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              line_end,
  output logic              v_sync,
  output logic              v_active,
  output logic [LINE_W-1:0] line_y,
  output logic              frame_start,
  output logic              frame_end
`ifdef VSYNC_FRAME_COUNT_EN
  ,
  output logic [7:0]        frame_count
`endif
);

  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FP_END   = V_ACTIVE + V_FP;
  localparam int unsigned SYNC_END = FP_END + V_SYNC;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } state_t;

  state_t            state, state_nxt;
  logic [LINE_W-1:0] line_nxt;
  logic              last_line;
  logic              fs_nxt, fe_nxt;
  logic              v_active_nxt, v_sync_nxt;

  // Region a line number falls into; zero-length porches are skipped
  // naturally because their range is empty.
  function automatic state_t region_of(input logic [LINE_W-1:0] l);
    int unsigned li;
    li = 32'(l);
    if (li < V_ACTIVE)      return ST_ACTIVE;
    else if (li < FP_END)   return ST_FRONT;
    else if (li < SYNC_END) return ST_SYNC;
    else                    return ST_BACK;
  endfunction

  // Next-state, next-line and next-output logic
  always_comb begin
    line_nxt     = line_y;
    state_nxt    = state;
    fs_nxt       = 1'b0;
    fe_nxt       = 1'b0;
    last_line    = (32'(line_y) == V_TOTAL - 1);
    if (line_end) begin
      line_nxt  = last_line ? '0 : line_y + LINE_W'(1);
      fs_nxt    = last_line;
      fe_nxt    = !last_line && (32'(line_y) == V_ACTIVE - 1);
      state_nxt = region_of(line_nxt);
    end
    v_active_nxt = (state_nxt == ST_ACTIVE);
    v_sync_nxt   = (state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // State and registered outputs
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ACTIVE;
      line_y      <= '0;
      v_active    <= 1'b1;
      v_sync      <= ~SYNC_POL;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_y      <= line_nxt;
      v_active    <= v_active_nxt;
      v_sync      <= v_sync_nxt;
      frame_start <= fs_nxt;
      frame_end   <= fe_nxt;
    end
  end

`ifdef VSYNC_FRAME_COUNT_EN
  // Completed-frame counter, wraps 255 -> 0
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (fs_nxt) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vertical_sync.sv
// ---------------------------------------------------------------------------
// tb_vertical_sync
// Self-checking bench for vertical_sync at default parameters. A line-number
// model derives every expected output from the frame timing rules.
// ---------------------------------------------------------------------------
module tb_vertical_sync;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LINE_W   = 10;

  logic              pixel_clk;
  logic              reset;
  logic              line_end;
  logic              v_sync;
  logic              v_active;
  logic [LINE_W-1:0] line_y;
  logic              frame_start;
  logic              frame_end;
`ifdef VSYNC_FRAME_COUNT_EN
  logic [7:0]        frame_count;
`endif

  vertical_sync dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .line_end    (line_end),
    .v_sync      (v_sync),
    .v_active    (v_active),
    .line_y      (line_y),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef VSYNC_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: line number plus last-edge pulse expectations
  int unsigned m_line = 0;
  logic        m_fs   = 1'b0;
  logic        m_fe   = 1'b0;
  int unsigned m_fc   = 0;

  function automatic logic exp_active();
    return (m_line < V_ACTIVE);
  endfunction

  function automatic logic exp_vsync();
    return !((m_line >= V_ACTIVE + V_FP) && (m_line < V_ACTIVE + V_FP + V_SYNC));
  endfunction

  // Drive one cycle of line_end and advance the model; sampled #1 after edge
  task automatic step(input logic le);
    @(negedge pixel_clk);
    line_end = le;
    @(posedge pixel_clk);
    #1;
    if (le) begin
      m_fs   = (m_line == V_TOTAL - 1);
      m_fe   = (m_line == V_ACTIVE - 1);
      m_line = (m_line + 1) % V_TOTAL;
      if (m_fs) m_fc = (m_fc + 1) % 256;
    end else begin
      m_fs = 1'b0;
      m_fe = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_fs = 1'b0; m_fe = 1'b0; m_fc = 0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    line_end = 1'b1;
    repeat (4) @(posedge pixel_clk);
    #1;
    model_reset();
    n_cmp++;
    if (line_y !== '0 || v_active !== 1'b1 || v_sync !== 1'b1 ||
        frame_start !== 1'b0 || frame_end !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got y=%0d act=%b vs=%b fs=%b fe=%b, expected y=0 act=1 vs=1 fs=0 fe=0",
               line_y, v_active, v_sync, frame_start, frame_end);
    end
`ifdef VSYNC_FRAME_COUNT_EN
    n_cmp++;
    if (frame_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
    end
`endif
    @(negedge pixel_clk);
    line_end = 1'b0;
    reset    = 1'b0;
    step(1'b0);
    n_cmp++;
    if (line_y !== '0 || frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got y=%0d fs=%b expected y=0 fs=0", line_y, frame_start);
    end
  endtask

  task automatic test_frame_end();
    repeat (479) step(1'b1);
    n_cmp++;
    if (line_y !== 10'd479 || v_active !== 1'b1 || frame_end !== 1'b0) begin
      n_err++;
      $display("FAIL line_479: got y=%0d act=%b fe=%b expected y=479 act=1 fe=0", line_y, v_active, frame_end);
    end
    step(1'b1);
    n_cmp++;
    if (line_y !== 10'd480 || v_active !== 1'b0 || frame_end !== 1'b1) begin
      n_err++;
      $display("FAIL line_480: got y=%0d act=%b fe=%b expected y=480 act=0 fe=1", line_y, v_active, frame_end);
    end
    step(1'b0);
    n_cmp++;
    if (frame_end !== 1'b0 || line_y !== 10'd480) begin
      n_err++;
      $display("FAIL frame_end_width: got fe=%b y=%0d expected fe=0 y=480", frame_end, line_y);
    end
  endtask

  task automatic test_vsync();
    repeat (9) step(1'b1);
    n_cmp++;
    if (line_y !== 10'd489 || v_sync !== 1'b1) begin
      n_err++;
      $display("FAIL vsync_489: got y=%0d vs=%b expected y=489 vs=1", line_y, v_sync);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1);
      n_cmp++;
      if (32'(line_y) !== m_line || v_sync !== 1'b0 || v_active !== 1'b0) begin
        n_err++;
        $display("FAIL vsync_low: got y=%0d vs=%b act=%b expected y=%0d vs=0 act=0",
                 line_y, v_sync, v_active, m_line);
      end
    end
    step(1'b1);
    n_cmp++;
    if (line_y !== 10'd492 || v_sync !== 1'b1) begin
      n_err++;
      $display("FAIL vsync_492: got y=%0d vs=%b expected y=492 vs=1", line_y, v_sync);
    end
  endtask

  task automatic test_frame_wrap();
    repeat (32) step(1'b1);
    n_cmp++;
    if (line_y !== 10'd524 || frame_start !== 1'b0 || v_active !== 1'b0) begin
      n_err++;
      $display("FAIL line_524: got y=%0d fs=%b act=%b expected y=524 fs=0 act=0", line_y, frame_start, v_active);
    end
    step(1'b1);
    n_cmp++;
    if (line_y !== '0 || v_active !== 1'b1 || frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_0: got y=%0d act=%b fs=%b expected y=0 act=1 fs=1", line_y, v_active, frame_start);
    end
    step(1'b0);
    n_cmp++;
    if (frame_start !== 1'b0 || line_y !== '0) begin
      n_err++;
      $display("FAIL frame_start_width: got fs=%b y=%0d expected fs=0 y=0", frame_start, line_y);
    end
  endtask

  // Two full frames, every cycle checked; second frame must replay the first
  task automatic test_two_frames();
    logic [LINE_W+3:0] rec[$];
    logic [LINE_W+3:0] cur;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < int'(V_TOTAL); i++) begin
        step(1'b1);
        cur = {line_y, v_active, v_sync, frame_start, frame_end};
        n_cmp++;
        if (32'(line_y) !== m_line || v_active !== exp_active() || v_sync !== exp_vsync() ||
            frame_start !== m_fs || frame_end !== m_fe) begin
          n_err++;
          $display("FAIL frame_seq: got y=%0d act=%b vs=%b fs=%b fe=%b expected y=%0d act=%b vs=%b fs=%b fe=%b",
                   line_y, v_active, v_sync, frame_start, frame_end,
                   m_line, exp_active(), exp_vsync(), m_fs, m_fe);
        end
        if (f == 0) begin
          rec.push_back(cur);
        end else begin
          n_cmp++;
          if (cur !== rec[i]) begin
            n_err++;
            $display("FAIL frame_repeat: line %0d got %h expected %h", i, cur, rec[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    while (m_line != 300) step(1'b1);
    @(negedge pixel_clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (line_y !== '0 || v_active !== 1'b1 || v_sync !== 1'b1 ||
        frame_start !== 1'b0 || frame_end !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got y=%0d act=%b vs=%b fs=%b fe=%b expected y=0 act=1 vs=1 fs=0 fe=0",
               line_y, v_active, v_sync, frame_start, frame_end);
    end
    line_end = 1'b1;
    @(negedge pixel_clk);
    line_end = 1'b0;
    reset    = 1'b0;
    step(1'b1);
    n_cmp++;
    if (line_y !== 10'd1 || frame_start !== 1'b0 || v_active !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_mid: got y=%0d fs=%b act=%b expected y=1 fs=0 act=1", line_y, frame_start, v_active);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned start;
    step(1'b0);
    start = 32'(line_y);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    n_cmp++;
    if (32'(line_y) !== (start + 2) % V_TOTAL || 32'(line_y) !== m_line) begin
      n_err++;
      $display("FAIL back_to_back: got y=%0d expected y=%0d", line_y, (start + 2) % V_TOTAL);
    end
  endtask

  // Random line_end density across several frames
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step(logic'(($urandom % 4) != 0));
      n_cmp++;
      if (32'(line_y) !== m_line || v_active !== exp_active() || v_sync !== exp_vsync() ||
          frame_start !== m_fs || frame_end !== m_fe) begin
        n_err++;
        $display("FAIL random_seq: got y=%0d act=%b vs=%b fs=%b fe=%b expected y=%0d act=%b vs=%b fs=%b fe=%b",
                 line_y, v_active, v_sync, frame_start, frame_end,
                 m_line, exp_active(), exp_vsync(), m_fs, m_fe);
      end
`ifdef VSYNC_FRAME_COUNT_EN
      n_cmp++;
      if (32'(frame_count) !== m_fc) begin
        n_err++;
        $display("FAIL random_frame_count: got %0d expected %0d", frame_count, m_fc);
      end
`endif
    end
  endtask

  initial begin
    reset    = 1'b1;
    line_end = 1'b0;
    test_reset();
    test_frame_end();
    test_vsync();
    test_frame_wrap();
    test_two_frames();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
